// File: rtl/phase_window_monitor.sv
// Purpose: checks the sequencer's A+B windows against EXP_LEN +/- TOL, counts them and times the C gap.
// Latency: events are taken at the edge where the input rises; outputs are registered and visible the next cycle.
// Backpressure: none; this is a passive observer that never stalls the sequencer.
//
// Ports:
//   cycle, rst_n            clock (rising edge) and asynchronous active-low reset
//   start_of_a, end_of_b    sequencer strobes; may be held as levels, only rising edges count
//   clr                     synchronous clear of FSM, counters and flags; discards same-cycle events
//   win_done                one-cycle pulse when a window closes
//   win_len, win_ok         length of the last closed window and whether it was in tolerance
//   win_count               closed windows, saturating
//   err_* / gap_timeout     sticky protocol/timing flags
//   mon_state               IDLE=0, WINDOW=1, GAP=2
module phase_window_monitor #(
  parameter int unsigned EXP_LEN     = 14,
  parameter int unsigned TOL         = 0,
  parameter int unsigned GAP_TIMEOUT = 64,
  parameter int unsigned CW          = 8,
  parameter int unsigned NW          = 16
) (
  input  logic          cycle,
  input  logic          rst_n,
  input  logic          start_of_a,
  input  logic          end_of_b,
  input  logic          clr,
  output logic          win_done,
  output logic [CW-1:0] win_len,
  output logic          win_ok,
  output logic [NW-1:0] win_count,
  output logic          err_short,
  output logic          err_long,
  output logic          err_orphan_end,
  output logic          err_dup_start,
  output logic          gap_timeout,
  output logic [1:0]    mon_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam int unsigned HI = EXP_LEN + TOL;
  // Lower bound clamps at zero so a tolerance wider than the window cannot wrap.
  localparam int unsigned LO = (EXP_LEN > TOL) ? (EXP_LEN - TOL) : 0;

  // The upper bound must leave headroom below the saturation value, otherwise a
  // saturated length would be indistinguishable from an in-range one.
  generate
    if (HI + 32'd1 >= (32'd1 << CW)) begin : g_bad_params
      $error("phase_window_monitor: EXP_LEN+TOL must be below 2**CW-1");
    end
  endgenerate

  state_t        state_q, state_d;
  logic          start_q, end_q;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] gap_q, gap_d;
  logic          win_done_q, win_done_d;
  logic [CW-1:0] win_len_q, win_len_d;
  logic          win_ok_q, win_ok_d;
  logic [NW-1:0] win_count_q, win_count_d;
  logic          err_short_q, err_short_d;
  logic          err_long_q, err_long_d;
  logic          err_orphan_q, err_orphan_d;
  logic          err_dup_q, err_dup_d;
  logic          gap_to_q, gap_to_d;

  logic          start_ev, end_ev;
  logic [CW:0]   len_inc, gap_inc;
  logic [CW-1:0] len_sat, gap_sat;
  logic [NW-1:0] cnt_sat;

  assign start_ev = start_of_a & ~start_q;
  assign end_ev   = end_of_b & ~end_q;

  // One extra bit on the increment exposes the carry used for saturation and
  // lets the timeout compare see the true count+1.
  assign len_inc = {1'b0, len_q} + {{CW{1'b0}}, 1'b1};
  assign gap_inc = {1'b0, gap_q} + {{CW{1'b0}}, 1'b1};
  assign len_sat = len_inc[CW] ? {CW{1'b1}} : len_inc[CW-1:0];
  assign gap_sat = gap_inc[CW] ? {CW{1'b1}} : gap_inc[CW-1:0];
  assign cnt_sat = (&win_count_q) ? win_count_q : (win_count_q + {{(NW-1){1'b0}}, 1'b1});

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    gap_d        = gap_q;
    win_done_d   = 1'b0;
    win_len_d    = win_len_q;
    win_ok_d     = win_ok_q;
    win_count_d  = win_count_q;
    err_short_d  = err_short_q;
    err_long_d   = err_long_q;
    err_orphan_d = err_orphan_q;
    err_dup_d    = err_dup_q;
    gap_to_d     = gap_to_q;

    if (clr) begin
      state_d      = IDLE;
      len_d        = '0;
      gap_d        = '0;
      win_len_d    = '0;
      win_ok_d     = 1'b0;
      win_count_d  = '0;
      err_short_d  = 1'b0;
      err_long_d   = 1'b0;
      err_orphan_d = 1'b0;
      err_dup_d    = 1'b0;
      gap_to_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ev) begin
            state_d = WINDOW;
            len_d   = '0;
          end
          if (end_ev) begin
            err_orphan_d = 1'b1;
          end
        end

        WINDOW: begin
          if (end_ev) begin
            // len_q counts edges since the start edge minus one, so +1 is the length.
            win_done_d  = 1'b1;
            win_len_d   = len_sat;
            win_count_d = cnt_sat;
            win_ok_d    = (32'(len_sat) >= LO) && (32'(len_sat) <= HI);
            if (32'(len_sat) < LO) err_short_d = 1'b1;
            if (32'(len_sat) > HI) err_long_d  = 1'b1;
            if (start_ev) begin
              // Back-to-back windows: zero-length gap, reopen straight away.
              len_d = '0;
            end else begin
              state_d = GAP;
              gap_d   = '0;
            end
          end else if (start_ev) begin
            err_dup_d = 1'b1;
            len_d     = '0;
          end else begin
            len_d = len_sat;
            // Flag an overrun as soon as it is certain, not only at close.
            if (32'(len_inc) > HI) err_long_d = 1'b1;
          end
        end

        GAP: begin
          gap_d = gap_sat;
          if (start_ev) begin
            state_d = WINDOW;
            len_d   = '0;
          end else if ((GAP_TIMEOUT != 0) && (32'(gap_inc) == GAP_TIMEOUT)) begin
            gap_to_d = 1'b1;
            state_d  = IDLE;
          end
          if (end_ev) begin
            err_orphan_d = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge cycle or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      len_q        <= '0;
      gap_q        <= '0;
      win_done_q   <= 1'b0;
      win_len_q    <= '0;
      win_ok_q     <= 1'b0;
      win_count_q  <= '0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_orphan_q <= 1'b0;
      err_dup_q    <= 1'b0;
      gap_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Edge-detect registers follow the inputs even through clr, so a level
      // held across clr does not produce a late event.
      start_q      <= start_of_a;
      end_q        <= end_of_b;
      len_q        <= len_d;
      gap_q        <= gap_d;
      win_done_q   <= win_done_d;
      win_len_q    <= win_len_d;
      win_ok_q     <= win_ok_d;
      win_count_q  <= win_count_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      err_orphan_q <= err_orphan_d;
      err_dup_q    <= err_dup_d;
      gap_to_q     <= gap_to_d;
    end
  end

  assign win_done       = win_done_q;
  assign win_len        = win_len_q;
  assign win_ok         = win_ok_q;
  assign win_count      = win_count_q;
  assign err_short      = err_short_q;
  assign err_long       = err_long_q;
  assign err_orphan_end = err_orphan_q;
  assign err_dup_start  = err_dup_q;
  assign gap_timeout    = gap_to_q;
  assign mon_state      = state_q;

endmodule

// File: tb/tb_phase_window_monitor.sv
// Purpose: directed, table-driven check of phase_window_monitor (EXP_LEN=14, TOL=0).
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Backpressure: not applicable.
module tb_phase_window_monitor;

  logic        cycle;
  logic        rst_n;
  logic        start_of_a;
  logic        end_of_b;
  logic        clr;

  logic        win_done;
  logic [7:0]  win_len;
  logic        win_ok;
  logic [15:0] win_count;
  logic        err_short, err_long, err_orphan_end, err_dup_start, gap_timeout;
  logic [1:0]  mon_state;

  logic        nt_win_done;
  logic [7:0]  nt_win_len;
  logic        nt_win_ok;
  logic [15:0] nt_win_count;
  logic        nt_err_short, nt_err_long, nt_err_orphan_end, nt_err_dup_start, nt_gap_timeout;
  logic [1:0]  nt_mon_state;

  phase_window_monitor #(
    .EXP_LEN(14), .TOL(0), .GAP_TIMEOUT(8), .CW(8), .NW(16)
  ) dut (
    .cycle(cycle), .rst_n(rst_n), .start_of_a(start_of_a), .end_of_b(end_of_b), .clr(clr),
    .win_done(win_done), .win_len(win_len), .win_ok(win_ok), .win_count(win_count),
    .err_short(err_short), .err_long(err_long), .err_orphan_end(err_orphan_end),
    .err_dup_start(err_dup_start), .gap_timeout(gap_timeout), .mon_state(mon_state)
  );

  // Same stimulus, timeout disabled.
  phase_window_monitor #(
    .EXP_LEN(14), .TOL(0), .GAP_TIMEOUT(0), .CW(8), .NW(16)
  ) dut_nt (
    .cycle(cycle), .rst_n(rst_n), .start_of_a(start_of_a), .end_of_b(end_of_b), .clr(clr),
    .win_done(nt_win_done), .win_len(nt_win_len), .win_ok(nt_win_ok), .win_count(nt_win_count),
    .err_short(nt_err_short), .err_long(nt_err_long), .err_orphan_end(nt_err_orphan_end),
    .err_dup_start(nt_err_dup_start), .gap_timeout(nt_gap_timeout), .mon_state(nt_mon_state)
  );

  initial cycle = 1'b0;
  always #5 cycle = ~cycle;

  typedef struct {
    string      nm;
    logic       s;
    logic       e;
    logic       c;
    int         cyc;
    logic       done;
    int         len;
    logic       ok;
    int         cnt;
    logic [4:0] err;  // {short, long, orphan_end, dup_start, gap_timeout}
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic add(input string nm, input logic s, input logic e, input logic c, input int cyc,
                     input logic done, input int len, input logic ok, input int cnt,
                     input logic [4:0] err, input logic [1:0] st);
    vec_t v;
    v.nm = nm; v.s = s; v.e = e; v.c = c; v.cyc = cyc;
    v.done = done; v.len = len; v.ok = ok; v.cnt = cnt; v.err = err; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic chk_all(input string nm, input logic done, input int len, input logic ok,
                         input int cnt, input logic [4:0] err, input logic [1:0] st);
    chk({nm, ".win_done"},  32'(win_done),  32'(done));
    chk({nm, ".win_len"},   32'(win_len),   len);
    chk({nm, ".win_ok"},    32'(win_ok),    32'(ok));
    chk({nm, ".win_count"}, 32'(win_count), cnt);
    chk({nm, ".errors"},
        32'({err_short, err_long, err_orphan_end, err_dup_start, gap_timeout}), 32'(err));
    chk({nm, ".mon_state"}, 32'(mon_state), 32'(st));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge cycle);
    #1;
  endtask

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start_of_a = 1'b0; end_of_b = 1'b0; clr = 1'b0;

    //  name                 s  e  c  cyc  done len ok cnt  err       st
    add("nom_open",          1, 0, 0, 1,   0,   0,  0, 0,   5'b00000, 2'd1);
    add("nom_hold",          1, 0, 0, 4,   0,   0,  0, 0,   5'b00000, 2'd1);
    add("nom_run",           0, 0, 0, 9,   0,   0,  0, 0,   5'b00000, 2'd1);
    add("nom_close",         0, 1, 0, 1,   1,   14, 1, 1,   5'b00000, 2'd2);
    add("nom_gap",           0, 0, 0, 1,   0,   14, 1, 1,   5'b00000, 2'd2);
    add("short_open",        1, 0, 0, 1,   0,   14, 1, 1,   5'b00000, 2'd1);
    add("short_run",         0, 0, 0, 9,   0,   14, 1, 1,   5'b00000, 2'd1);
    add("short_close",       0, 1, 0, 1,   1,   10, 0, 2,   5'b10000, 2'd2);
    add("short_gap",         0, 0, 0, 1,   0,   10, 0, 2,   5'b10000, 2'd2);
    add("long_open",         1, 0, 0, 1,   0,   10, 0, 2,   5'b10000, 2'd1);
    add("long_at_limit",     0, 0, 0, 14,  0,   10, 0, 2,   5'b10000, 2'd1);
    add("long_early_flag",   0, 0, 0, 1,   0,   10, 0, 2,   5'b11000, 2'd1);
    add("long_run",          0, 0, 0, 4,   0,   10, 0, 2,   5'b11000, 2'd1);
    add("long_close",        0, 1, 0, 1,   1,   20, 0, 3,   5'b11000, 2'd2);
    add("long_gap",          0, 0, 0, 1,   0,   20, 0, 3,   5'b11000, 2'd2);
    add("gap_before_to",     0, 0, 0, 6,   0,   20, 0, 3,   5'b11000, 2'd2);
    add("gap_timeout",       0, 0, 0, 1,   0,   20, 0, 3,   5'b11001, 2'd0);
    add("orphan_idle",       0, 1, 0, 1,   0,   20, 0, 3,   5'b11101, 2'd0);
    add("orphan_level",      0, 1, 0, 2,   0,   20, 0, 3,   5'b11101, 2'd0);
    add("clr_all",           0, 0, 1, 1,   0,   0,  0, 0,   5'b00000, 2'd0);
    add("clr_after",         0, 0, 0, 1,   0,   0,  0, 0,   5'b00000, 2'd0);
    add("dup_open1",         1, 0, 0, 1,   0,   0,  0, 0,   5'b00000, 2'd1);
    add("dup_run1",          0, 0, 0, 5,   0,   0,  0, 0,   5'b00000, 2'd1);
    add("dup_second",        1, 0, 0, 1,   0,   0,  0, 0,   5'b00010, 2'd1);
    add("dup_run2",          0, 0, 0, 13,  0,   0,  0, 0,   5'b00010, 2'd1);
    add("dup_close",         0, 1, 0, 1,   1,   14, 1, 1,   5'b00010, 2'd2);
    add("dup_gap",           0, 0, 0, 1,   0,   14, 1, 1,   5'b00010, 2'd2);
    add("clr_dup",           0, 0, 1, 1,   0,   0,  0, 0,   5'b00000, 2'd0);
    add("sim_open",          1, 0, 0, 1,   0,   0,  0, 0,   5'b00000, 2'd1);
    add("sim_run",           0, 0, 0, 13,  0,   0,  0, 0,   5'b00000, 2'd1);
    add("sim_close_reopen",  1, 1, 0, 1,   1,   14, 1, 1,   5'b00000, 2'd1);
    add("sim_reopen_run",    0, 0, 0, 13,  0,   14, 1, 1,   5'b00000, 2'd1);
    add("sim_second_close",  0, 1, 0, 1,   1,   14, 1, 2,   5'b00000, 2'd2);
    add("sim_gap",           0, 0, 0, 1,   0,   14, 1, 2,   5'b00000, 2'd2);
    add("clre_open",         1, 0, 0, 1,   0,   14, 1, 2,   5'b00000, 2'd1);
    add("clre_run",          0, 0, 0, 13,  0,   14, 1, 2,   5'b00000, 2'd1);
    add("clr_vs_end",        0, 1, 1, 1,   0,   0,  0, 0,   5'b00000, 2'd0);
    add("clr_end_discarded", 0, 1, 0, 1,   0,   0,  0, 0,   5'b00000, 2'd0);
    add("clr_end_released",  0, 0, 0, 1,   0,   0,  0, 0,   5'b00000, 2'd0);

    // Reset values.
    step(3);
    chk_all("reset", 1'b0, 0, 1'b0, 0, 5'b00000, 2'd0);
    @(negedge cycle);
    rst_n = 1'b1;
    step(1);

    foreach (tbl[i]) begin
      start_of_a = tbl[i].s;
      end_of_b   = tbl[i].e;
      clr        = tbl[i].c;
      step(tbl[i].cyc);
      chk_all(tbl[i].nm, tbl[i].done, tbl[i].len, tbl[i].ok, tbl[i].cnt, tbl[i].err, tbl[i].st);
    end
    start_of_a = 1'b0; end_of_b = 1'b0; clr = 1'b0;

    // Long gap: the timed instance times out, the disabled one stays in GAP.
    start_of_a = 1'b1; step(1);
    start_of_a = 1'b0; step(13);
    end_of_b   = 1'b1; step(1);
    end_of_b   = 1'b0; step(300);
    chk("nogap.nt_mon_state",   32'(nt_mon_state),   32'd2);
    chk("nogap.nt_gap_timeout", 32'(nt_gap_timeout), 32'd0);
    chk("nogap.nt_win_count",   32'(nt_win_count),   32'd1);
    chk("nogap.nt_win_len",     32'(nt_win_len),     32'd14);
    chk("nogap.nt_win_ok",      32'(nt_win_ok),      32'd1);
    chk("nogap.nt_win_done",    32'(nt_win_done),    32'd0);
    chk("nogap.nt_other_errs",
        32'({nt_err_short, nt_err_long, nt_err_orphan_end, nt_err_dup_start}), 32'd0);
    chk("nogap.gap_timeout",    32'(gap_timeout),    32'd1);
    chk("nogap.mon_state",      32'(mon_state),      32'd0);

    // Asynchronous reset in the middle of a window.
    start_of_a = 1'b1; step(1);
    start_of_a = 1'b0; step(5);
    chk("midrst.pre_state", 32'(mon_state), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("midrst_async", 1'b0, 0, 1'b0, 0, 5'b00000, 2'd0);
    @(negedge cycle);
    @(negedge cycle);
    rst_n = 1'b1;
    step(1);
    chk_all("midrst_released", 1'b0, 0, 1'b0, 0, 5'b00000, 2'd0);
    start_of_a = 1'b1; step(1);
    start_of_a = 1'b0; step(13);
    end_of_b   = 1'b1; step(1);
    chk_all("midrst_window", 1'b1, 14, 1'b1, 1, 5'b00000, 2'd2);
    end_of_b   = 1'b0; step(1);
    chk("midrst.done_pulse", 32'(win_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/phase_window_monitor.md
# phase_window_monitor

Downstream checker for the phase-sequencing FSM. Consumes its `start_of_a` and `end_of_b` outputs and measures each A+B window (start of A to end of B) against an expected length. Counts completed windows, flags protocol violations, and times the C-phase gap between windows. Sits between the sequencer and the status/debug register bank; drives no datapath.

## Interface
- `EXP_LEN`, 14: expected window length in cycles (A = 5 + B = 9).
- `TOL`, 0: allowed ± deviation from `EXP_LEN`.
- `GAP_TIMEOUT`, 64: maximum cycles in GAP before a timeout; 0 disables the check.
- `CW`, 8: width of the window-length and gap counters.
- `NW`, 16: width of the window counter.

Ports:
- `cycle` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_of_a` in 1: from the sequencer; may be held high as a level.
- `end_of_b` in 1: from the sequencer; may be held high as a level.
- `clr` in 1: synchronous clear of counts, flags and FSM.
- `win_done` out 1: one-cycle pulse when a window closes.
- `win_len` out CW: length of the last closed window.
- `win_ok` out 1: last window within `EXP_LEN` ± `TOL`.
- `win_count` out NW: closed windows, saturating.
- `err_short`, `err_long`, `err_orphan_end`, `err_dup_start`, `gap_timeout` out 1 each: sticky error flags.
- `mon_state` out 2: IDLE=0, WINDOW=1, GAP=2.

## Operation
- **Edge detection.** Each input is registered (`*_q`).
  - Event = `in & ~in_q`.
  - A level held high for N cycles produces exactly one event.
  - `*_q` are cleared by reset only, never by `clr`.
- **IDLE.**
  - start event → WINDOW, `len_cnt` ← 0.
  - end event → set `err_orphan_end`, stay in IDLE.
- **WINDOW.** `len_cnt` increments every cycle, saturating at 2^CW−1.
  - end event: `win_len` ← sat(`len_cnt`+1), pulse `win_done`, `win_count`++ (saturating), update `win_ok`.
    - Set `err_short` if `win_len` < `EXP_LEN`−`TOL`.
    - Set `err_long` if `win_len` > `EXP_LEN`+`TOL`.
    - Go to GAP with `gap_cnt` ← 0.
  - Elapsed count (`len_cnt`+1) exceeds `EXP_LEN`+`TOL` with no end event yet: set `err_long` immediately and stay in WINDOW.
  - start event without end event: set `err_dup_start`, restart the window (`len_cnt` ← 0), no `win_done`.
  - start and end events in the same cycle: close the window as above, then immediately reopen → WINDOW, `len_cnt` ← 0. This is a zero-length gap, not an error.
- **GAP.** `gap_cnt` increments, saturating.
  - start event → WINDOW, `len_cnt` ← 0.
  - end event → set `err_orphan_end`, stay in GAP.
  - `GAP_TIMEOUT` ≠ 0 and `gap_cnt`+1 == `GAP_TIMEOUT` with no start event: set `gap_timeout`, go to IDLE.
- **Sticky flags.** Cleared only by reset or `clr`.
- **`clr` priority.** `clr` overrides all events in its cycle.
  - FSM → IDLE; counters, `win_len`, `win_ok`, `win_count` and flags → 0; `win_done` → 0.
  - Events present in the `clr` cycle are discarded.
- **Arithmetic.** All comparisons are unsigned at CW bits. `EXP_LEN`+`TOL` must be < 2^CW−1; this is checked by an elaboration assertion.

## Timing
- **Reset (`rst_n` low), asynchronous.** `mon_state`=IDLE. Every output is 0: `win_done`, `win_len`, `win_ok`, `win_count`, all error flags. `*_q`, `len_cnt` and `gap_cnt` are 0.
- **Input sampling.** Inputs are sampled on rising `cycle`. An event is recognised at the first edge where the input is 1 and `*_q` is 0.
- **Window length.** `win_len` = number of edges from the start-event edge to the end-event edge. Example: start at edge t0, end at edge t0+14 → `win_len` = 14.
- **Output latency.** All outputs are registered. `win_done`, `win_len`, `win_ok`, `win_count` and error flags change at the edge where the event is recognised; they are visible in the following cycle. `win_done` is high for exactly one cycle.
- **Reset mid-window.** Aborts the window with no `win_done`. After release, the first start event begins a fresh window.

## Test plan
- **Nominal window.** Reset, then `start_of_a` held high 5 cycles; `end_of_b` pulses 14 edges after the `start_of_a` rise. Required: single `win_done`, `win_len`=14, `win_ok`=1, `win_count`=1, no flags, `mon_state`=GAP.
- **Short and long windows.** With `TOL`=0, a window of 10 cycles → `err_short`=1, `win_ok`=0. A window of 20 cycles → `err_long` rises at the 15th edge, before `end_of_b`; at close, `win_len`=20.
- **Protocol errors.**
  - `end_of_b` from IDLE → `err_orphan_end`=1, `mon_state`=IDLE.
  - Two `start_of_a` rises 6 cycles apart → `err_dup_start`=1; the next end measures from the second start.
- **Gap timeout.** With `GAP_TIMEOUT`=8, close a window and send no start → `gap_timeout`=1 and `mon_state`=IDLE 8 edges after close. Repeat with `GAP_TIMEOUT`=0 for 300 cycles → no timeout; `gap_cnt` saturates.
- **Simultaneous events and `clr`.**
  - start and end events in the same cycle → `win_done` plus an immediate WINDOW with no error.
  - `clr` asserted in the same cycle as an end event → no `win_done`; everything is 0 and `mon_state`=IDLE next cycle.
- **Reset mid-window.** Drop `rst_n` asynchronously mid-window → outputs are 0 immediately. After release, a 14-cycle window gives `win_count`=1.
